intpol_ctrl_fsm_gen: RTL and testbench

Parametrised control FSM for the interpolator datapath. It supports a runtime interpolation factor, NCH time-multiplexed channels and internal prime/phase/channel counters, so comparators are no longer external. The block sits between the input FIFO (empty), the address/coefficient/accumulator datapath and the output FIFO (afull). It also provides a bypass pass-through mode and a graceful stop.

---
 rtl/intpol_ctrl_fsm_gen_if.sv | 42 ++++
 rtl/intpol_ctrl_fsm_gen.sv | 207 ++++++++++++++++++++
 tb/tb_intpol_ctrl_fsm_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/intpol_ctrl_fsm_gen_if.sv
// Handshake/control bundle between the interpolator control FSM and its surroundings.
// master = FSM side, slave = datapath/FIFO/controller side.
interface intpol_ctrl_fsm_gen_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned CH_W  = 1
);
  logic             start;
  logic             stop;
  logic             bypass;
  logic [CNT_W-1:0] factor;
  logic             empty;
  logic             afull;
  logic             busy;
  logic             rd_en;
  logic             en_addr;
  logic             op_1;
  logic             ld_p1_xi;
  logic             sel_mult;
  logic             en_sum;
  logic             ld_data;
  logic             wr_en;
  logic             en_stream;
  logic             stop_empty;
  logic             stop_afull;
  logic [CH_W-1:0]  ch_idx;
  logic [CNT_W-1:0] phase;
  logic             sample_done;
  logic             done;
  logic             clear;

  modport master (
    input  start, stop, bypass, factor, empty, afull,
    output busy, rd_en, en_addr, op_1, ld_p1_xi, sel_mult, en_sum, ld_data, wr_en,
           en_stream, stop_empty, stop_afull, ch_idx, phase, sample_done, done, clear
  );

  modport slave (
    output start, stop, bypass, factor, empty, afull,
    input  busy, rd_en, en_addr, op_1, ld_p1_xi, sel_mult, en_sum, ld_data, wr_en,
           en_stream, stop_empty, stop_afull, ch_idx, phase, sample_done, done, clear
  );
endinterface

// File: rtl/intpol_ctrl_fsm_gen.sv
// Interpolator control FSM: prime, per-sample diff/load/out loop over phases x channels,
// steady-state fetch, bypass pass-through, graceful stop and restart via CLEAR.
module intpol_ctrl_fsm_gen #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned NCH     = 2,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned PRIME_N = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  intpol_ctrl_fsm_gen_if.master bus
);

  localparam int unsigned PrimeTot = PRIME_N * NCH;
  localparam int unsigned PcW      = $clog2(PrimeTot + 1);

  typedef enum logic [3:0] {
    StIdle, StPrime, StDiff, StLoad, StOut, StSdone, StFetch, StBypass, StClear
  } state_e;

  state_e           state_q, state_d;
  logic [PcW-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] l_q, l_d;
  logic             stop_q, stop_d;
  logic             wr_en_q;
  logic [CNT_W-1:0] l_new;
  logic [CH_W-1:0]  ch_inc;

  assign l_new  = (bus.factor == '0) ? CNT_W'(1) : bus.factor;
  assign ch_inc = (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ch_d            = ch_q;
    phase_d         = phase_q;
    l_d             = l_q;
    stop_d          = stop_q;
    bus.busy        = 1'b0;
    bus.rd_en       = 1'b0;
    bus.en_addr     = 1'b0;
    bus.op_1        = 1'b0;
    bus.ld_p1_xi    = 1'b0;
    bus.sel_mult    = 1'b0;
    bus.en_sum      = 1'b0;
    bus.ld_data     = 1'b0;
    bus.wr_en       = 1'b0;
    bus.en_stream   = 1'b0;
    bus.stop_empty  = 1'b0;
    bus.stop_afull  = 1'b0;
    bus.ch_idx      = '0;
    bus.phase       = '0;
    bus.sample_done = 1'b0;
    bus.done        = 1'b0;
    bus.clear       = 1'b0;

    // Everything is held at zero while reset is asserted.
    if (rstn) begin
      bus.busy   = (state_q != StIdle);
      bus.clear  = bus.start || (state_q == StClear);
      bus.ch_idx = ch_q;
      bus.phase  = phase_q;
      bus.wr_en  = wr_en_q;
      if (state_q != StIdle) stop_d = stop_q | bus.stop;

      if (bus.start && state_q != StIdle && state_q != StClear) begin
        state_d = StClear;
        cnt_d   = '0;
        ch_d    = '0;
        phase_d = '0;
        stop_d  = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              l_d     = l_new;
              stop_d  = 1'b0;
              cnt_d   = '0;
              ch_d    = '0;
              phase_d = '0;
              state_d = bus.bypass ? StBypass : StPrime;
            end
          end
          StClear: begin
            cnt_d   = '0;
            ch_d    = '0;
            phase_d = '0;
            if (!bus.start) begin
              l_d     = l_new;
              state_d = bus.bypass ? StBypass : StPrime;
            end
          end
          StPrime: begin
            if (bus.empty) begin
              bus.stop_empty = 1'b1;
            end else begin
              bus.rd_en   = 1'b1;
              bus.en_addr = 1'b1;
              if (cnt_q == PcW'(PrimeTot - 1)) begin
                cnt_d   = '0;
                state_d = StDiff;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          StDiff: begin
            bus.op_1 = 1'b1;
            ch_d     = '0;
            phase_d  = '0;
            state_d  = StLoad;
          end
          StLoad: begin
            bus.ld_p1_xi = 1'b1;
            state_d      = StOut;
          end
          StOut: begin
            bus.sel_mult = 1'b1;
            if (bus.afull) begin
              bus.stop_afull = 1'b1;
            end else begin
              bus.ld_data = 1'b1;
              if (ch_q != CH_W'(NCH - 1)) begin
                ch_d    = ch_q + 1'b1;
                state_d = StLoad;
              end else begin
                ch_d = '0;
                if (phase_q < l_q - CNT_W'(1)) begin
                  phase_d    = phase_q + 1'b1;
                  bus.en_sum = 1'b1;
                  state_d    = StLoad;
                end else begin
                  phase_d = '0;
                  state_d = StSdone;
                end
              end
            end
          end
          StSdone: begin
            bus.sample_done = 1'b1;
            if (stop_q || bus.stop) begin
              bus.done = 1'b1;
              state_d  = StIdle;
            end else begin
              cnt_d   = '0;
              state_d = StFetch;
            end
          end
          StFetch: begin
            bus.en_stream = 1'b1;
            if (bus.empty) begin
              bus.stop_empty = 1'b1;
            end else begin
              bus.rd_en   = 1'b1;
              bus.en_addr = 1'b1;
              if (cnt_q == PcW'(NCH - 1)) begin
                cnt_d   = '0;
                state_d = StDiff;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          StBypass: begin
            if (stop_q || bus.stop) begin
              bus.done = 1'b1;
              ch_d     = '0;
              state_d  = StIdle;
            end else begin
              bus.stop_empty = bus.empty;
              bus.stop_afull = bus.afull;
              if (!bus.empty && !bus.afull) begin
                bus.rd_en   = 1'b1;
                bus.ld_data = 1'b1;
                ch_d        = ch_inc;
              end
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ch_q    <= '0;
      phase_q <= '0;
      l_q     <= '0;
      stop_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      phase_q <= phase_d;
      l_q     <= l_d;
      stop_q  <= stop_d;
      wr_en_q <= bus.ld_data;
    end
  end

endmodule

// File: tb/tb_intpol_ctrl_fsm_gen.sv
// Directed bench for intpol_ctrl_fsm_gen (NCH=2, PRIME_N=2, CNT_W=8).
module tb_intpol_ctrl_fsm_gen;
  localparam int unsigned CNT_W = 8, NCH = 2, CH_W = 1, PRIME_N = 2;

  logic clk = 1'b0;
  logic rstn;

  intpol_ctrl_fsm_gen_if #(.CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  intpol_ctrl_fsm_gen #(
    .CNT_W(CNT_W), .NCH(NCH), .CH_W(CH_W), .PRIME_N(PRIME_N)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_ld = 1'b0;
  int   ld_q[$], rd_q[$], sd_q[$], dn_q[$], exp_q[$];
  int   n_sum, n_se, n_sa, n_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_q(input string tag, input int q[$], input int e[$]);
    chk({tag, "_count"}, q.size(), e.size());
    for (int i = 0; i < e.size() && i < q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), q[i], e[i]);
  endtask

  function automatic int ent(input int k, input int ch, input int ph);
    return k * 256 + ch * 16 + ph;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Runs n cycles with per-cycle empty/afull/stop masks, logging events by cycle index.
  task automatic observe(input int n, input logic [63:0] em, input logic [63:0] am,
                         input logic [63:0] sm);
    ld_q.delete(); rd_q.delete(); sd_q.delete(); dn_q.delete();
    n_sum = 0; n_se = 0; n_sa = 0; n_idle = 0;
    for (int k = 0; k < n; k++) begin
      bus.empty = em[k];
      bus.afull = am[k];
      bus.stop  = sm[k];
      #1;
      chk($sformatf("wr_en_trail@%0d", k), bus.wr_en, prev_ld);
      chk($sformatf("rd_while_empty@%0d", k), bus.rd_en & bus.empty, 0);
      if (bus.ld_data) ld_q.push_back(ent(k, int'(bus.ch_idx), int'(bus.phase)));
      if (bus.rd_en) rd_q.push_back(k);
      if (bus.sample_done) sd_q.push_back(k);
      if (bus.done) dn_q.push_back(k);
      if (bus.en_sum) n_sum++;
      if (bus.stop_empty) n_se++;
      if (bus.stop_afull) n_sa++;
      if (!bus.busy) n_idle++;
      prev_ld = bus.ld_data;
      nxt();
    end
    bus.stop = 1'b0;
  endtask

  task automatic kick(input logic [7:0] fac, input logic byp, input string tag);
    bus.start = 1'b1; bus.factor = fac; bus.bypass = byp;
    bus.empty = 1'b0; bus.afull = 1'b0; bus.stop = 1'b0;
    #1;
    chk({tag, "_clear"}, bus.clear, 1);
    chk({tag, "_ld"}, bus.ld_data, 0);
    chk({tag, "_rd"}, bus.rd_en, 0);
    nxt();
    bus.start = 1'b0;
    prev_ld   = 1'b0;
  endtask

  task automatic clear_cycle(input string tag);
    bus.start = 1'b0;
    #1;
    chk({tag, "_clr_clear"}, bus.clear, 1);
    chk({tag, "_clr_busy"}, bus.busy, 1);
    chk({tag, "_clr_rd"}, bus.rd_en, 0);
    chk({tag, "_clr_ch"}, bus.ch_idx, 0);
    prev_ld = bus.ld_data;
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; bus.start = 1'b1; bus.stop = 1'b0; bus.bypass = 1'b0;
    bus.factor = 8'd4; bus.empty = 1'b0; bus.afull = 1'b0;
    #3;
    chk("rst_clear", bus.clear, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd", bus.rd_en, 0);
    bus.start = 1'b0;
    nxt();
    rstn = 1'b1;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_wr_en", bus.wr_en, 0);

    // Factor 4, free-flowing FIFOs; factor changed after start must not matter.
    kick(8'd4, 1'b0, "s1");
    bus.factor = 8'd9;
    observe(24, 64'h0, 64'h0, 64'h0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(6 + 2 * i, i % 2, i / 2));
    chk_q("s1_ld", ld_q, exp_q);
    chk_q("s1_rd", rd_q, '{0, 1, 2, 3, 22, 23});
    chk_q("s1_sd", sd_q, '{21});
    chk("s1_en_sum", n_sum, 3);
    chk("s1_done", dn_q.size(), 0);

    // Second sample: afull for 5 OUT cycles, then empty for 3 FETCH cycles.
    observe(28, 64'h0380_0000, 64'h7C, 64'h0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(7 + 2 * i, i % 2, i / 2));
    chk_q("s3_ld", ld_q, exp_q);
    chk_q("s3_rd", rd_q, '{26, 27});
    chk_q("s3_sd", sd_q, '{22});
    chk("s3_stop_afull", n_sa, 5);
    chk("s3_stop_empty", n_se, 3);
    chk("s3_en_sum", n_sum, 3);

    // Third sample: stop pulsed mid-sample, sample completes, then halt.
    observe(19, 64'h0, 64'h0, 64'h10);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(2 + 2 * i, i % 2, i / 2));
    chk_q("s4_ld", ld_q, exp_q);
    chk_q("s4_sd", sd_q, '{17});
    chk_q("s4_done", dn_q, '{17});
    chk("s4_idle_cycles", n_idle, 1);

    // Factor 0 acts as 1; empty for two PRIME cycles.
    kick(8'd0, 1'b0, "s2");
    observe(20, 64'h6, 64'h0, 64'h0);
    chk_q("s2_ld", ld_q, '{ent(8, 0, 0), ent(10, 1, 0), ent(16, 0, 0), ent(18, 1, 0)});
    chk_q("s2_rd", rd_q, '{0, 3, 4, 5, 12, 13});
    chk_q("s2_sd", sd_q, '{11, 19});
    chk("s2_stop_empty", n_se, 2);
    chk("s2_en_sum", n_sum, 0);

    // Restart during the second OUT of a sample with factor 2.
    observe(6, 64'h0, 64'h0, 64'h0);
    bus.empty = 1'b0;
    #1;
    chk("s5_out_ch", bus.ch_idx, 1);
    chk("s5_out_sel", bus.sel_mult, 1);
    kick(8'd2, 1'b0, "s5");
    clear_cycle("s5");
    observe(14, 64'h0, 64'h0, 64'h0);
    chk_q("s5_ld", ld_q, '{ent(6, 0, 0), ent(8, 1, 0), ent(10, 0, 1), ent(12, 1, 1)});
    chk_q("s5_rd", rd_q, '{0, 1, 2, 3});
    chk_q("s5_sd", sd_q, '{13});
    chk("s5_en_sum", n_sum, 1);

    // Restart into bypass, then reset mid-bypass.
    kick(8'd3, 1'b1, "s6");
    clear_cycle("s6");
    observe(6, 64'h4, 64'h10, 64'h0);
    chk_q("s6_ld", ld_q, '{ent(0, 0, 0), ent(1, 1, 0), ent(3, 0, 0), ent(5, 1, 0)});
    chk_q("s6_rd", rd_q, '{0, 1, 3, 5});
    chk("s6_stop_empty", n_se, 1);
    chk("s6_stop_afull", n_sa, 1);
    rstn = 1'b0; bus.empty = 1'b0; bus.afull = 1'b0; bus.start = 1'b1;
    #1;
    chk("s6_rst_rd", bus.rd_en, 0);
    chk("s6_rst_ld", bus.ld_data, 0);
    chk("s6_rst_wr_en", bus.wr_en, 0);
    chk("s6_rst_busy", bus.busy, 0);
    chk("s6_rst_clear", bus.clear, 0);
    bus.start = 1'b0;
    nxt();
    rstn = 1'b1;
    #1;
    chk("s6_post_busy", bus.busy, 0);
    chk("s6_post_rd", bus.rd_en, 0);
    chk("s6_post_wr_en", bus.wr_en, 0);
    prev_ld = 1'b0;

    // Bypass halted by stop while input is empty.
    kick(8'd5, 1'b1, "s7");
    observe(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h2);
    chk_q("s7_done", dn_q, '{1});
    chk("s7_idle_cycles", n_idle, 1);
    chk("s7_ld", ld_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
